// File: rtl/rs_pkg.sv
// GF(256) types and helpers for the Reed-Solomon encoder: field 0x11D, alpha = 0x02, first root alpha^0.
package rs_pkg;

    localparam logic [7:0] GF_POLY  = 8'h1D;
    localparam int         NPAR_DEF = 16;
    localparam int         NPAR_MAX = 32;

    typedef logic [7:0] gf_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        PAR  = 2'd2
    } rs_state_e;

    function automatic gf_t gf_mul(input gf_t a, input gf_t b);
        gf_t acc;
        gf_t sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ GF_POLY) : {sh[6:0], 1'b0};
        end
        return acc;
    endfunction

    // Non-leading coefficients of monic prod(x + alpha^i); byte j holds the x^j coefficient.
    function automatic logic [8*NPAR_MAX-1:0] calc_gen_poly(input int npar);
        gf_t                   c [0:NPAR_MAX];
        gf_t                   root;
        logic [8*NPAR_MAX-1:0] res;
        for (int j = 0; j <= NPAR_MAX; j++) begin
            c[j] = '0;
        end
        c[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < NPAR_MAX; i++) begin
            if (i < npar) begin
                for (int j = NPAR_MAX; j >= 1; j--) begin
                    c[j] = c[j-1] ^ gf_mul(c[j], root);
                end
                c[0] = gf_mul(c[0], root);
                root = gf_mul(root, 8'h02);
            end
        end
        res = '0;
        for (int j = 0; j < NPAR_MAX; j++) begin
            res[j*8 +: 8] = c[j];
        end
        return res;
    endfunction

    localparam logic [8*NPAR_MAX-1:0] GEN_POLY_ALL = calc_gen_poly(NPAR_DEF);
    localparam logic [8*NPAR_DEF-1:0] GEN_POLY     = GEN_POLY_ALL[8*NPAR_DEF-1:0];

endpackage

// File: rtl/rs_gf_cmul.sv
// GF(256) multiply of a variable operand by a compile-time constant coefficient.
module rs_gf_cmul
    import rs_pkg::*;
#(
    parameter logic [7:0] COEF = 8'h01
) (
    input  logic [7:0] a_i,
    output logic [7:0] p_o
);

    assign p_o = gf_mul(a_i, COEF);

endmodule

// File: rtl/rs_encoder_256.sv
// Systematic RS encoder over GF(256): k message bytes pass through, then NPAR parity bytes from an LFSR divider.
// Define RS_ERR_INJECT_EN to add inj_mask, XORed into every symbol as it enters the output slot.
module rs_encoder_256
    import rs_pkg::*;
#(
    parameter int NPAR = NPAR_DEF,
    parameter int KMAX = 239
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] msg_len,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
`ifdef RS_ERR_INJECT_EN
    input  logic [7:0] inj_mask,
`endif
    output logic       busy
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_MSG  = MSG;
    localparam logic [1:0] S_PAR  = PAR;

    localparam logic [8*NPAR_MAX-1:0] GEN_ALL  = calc_gen_poly(NPAR);
    localparam logic [7:0]            K_MAX    = 8'(KMAX);
    localparam logic [7:0]            PAR_LAST = 8'(NPAR - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] k_q, k_d;
    logic [7:0] cnt_q, cnt_d;
    gf_t        r_q [NPAR];
    gf_t        r_d [NPAR];
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_last_q, out_last_d;

    gf_t        fb;
    gf_t        prod [NPAR];
    logic       slot_free;
    logic       msg_xfer;
    logic       start_ok;
    logic [7:0] mask;

`ifdef RS_ERR_INJECT_EN
    assign mask = inj_mask;
`else
    assign mask = 8'h00;
`endif

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == S_MSG) && slot_free;
    assign msg_xfer  = in_ready && in_valid;
    assign start_ok  = start && (msg_len != 8'd0) && (msg_len <= K_MAX);
    assign fb        = in_data ^ r_q[NPAR-1];

    generate
        for (genvar gi = 0; gi < NPAR; gi++) begin : g_cmul
            rs_gf_cmul #(
                .COEF(GEN_ALL[gi*8 +: 8])
            ) u_cmul (
                .a_i(fb),
                .p_o(prod[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        case (state_q)
            S_IDLE: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                if (start_ok) begin
                    state_d = S_MSG;
                    k_d     = msg_len;
                    cnt_d   = 8'd0;
                    for (int j = 0; j < NPAR; j++) begin
                        r_d[j] = '0;
                    end
                end
            end
            S_MSG: begin
                if (msg_xfer) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data ^ mask;
                    out_last_d  = 1'b0;
                    r_d[0]      = prod[0];
                    for (int j = 1; j < NPAR; j++) begin
                        r_d[j] = r_q[j-1] ^ prod[j];
                    end
                    // Switch to parity on the k-th symbol so the first parity byte follows without a gap.
                    if (cnt_q == k_q - 8'd1) begin
                        state_d = S_PAR;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (slot_free) begin
                    out_valid_d = 1'b0;
                end
            end
            S_PAR: begin
                if (slot_free) begin
                    if (out_valid_q && out_last_q) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = r_q[NPAR-1] ^ mask;
                        out_last_d  = (cnt_q == PAR_LAST);
                        r_d[0]      = '0;
                        for (int j = 1; j < NPAR; j++) begin
                            r_d[j] = r_q[j-1];
                        end
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= 8'd0;
            cnt_q       <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_last_q  <= 1'b0;
            for (int j = 0; j < NPAR; j++) begin
                r_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            r_q         <= r_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != S_IDLE);

endmodule
